// File: rtl/exe_mdu.sv
// exe_mdu: EXE-stage MULT/MULTU/DIV/DIVU and MTHI/MTLO unit that owns the architectural HI/LO registers.
// Latency: MULT/MULTU busy 1+MUL_CYCLES cycles, DIV/DIVU busy 34 (1 on divide-by-zero), then a one-cycle DONE; MTHI/MTLO write at the edge.
// Backpressure: EXE_MDUBusy holds IF..EXE until HI/LO carry the result; EXE_Flush aborts any op at the next edge.
module exe_mdu #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EXE_Flush,
  input  logic        EXE_MDUValid,
  input  logic [2:0]  EXE_MDUOp,
  input  logic [31:0] EXE_SrcA,
  input  logic [31:0] EXE_SrcB,
  output logic        EXE_MDUBusy,
  output logic        MDU_Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [5:0] MUL_CNT_INIT = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_CNT_INIT = 6'd32;

  logic [1:0]  state;
  logic [5:0]  cnt;
  // MUL: raw operands. DIV: op_a is the dividend magnitude shifting into the quotient, op_b the divisor magnitude.
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] rem;
  logic        is_signed;
  logic        neg_q;
  logic        neg_r;

  logic        is_mul_op;
  logic        is_div_op;
  logic        op_signed;
  logic        start;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] product;
  logic [32:0] trial;
  logic [32:0] trial_diff;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  // Decode the incoming op, build the start condition and the datapath helpers.
  always_comb begin
    is_mul_op = (EXE_MDUOp == OP_MULT) || (EXE_MDUOp == OP_MULTU);
    is_div_op = (EXE_MDUOp == OP_DIV) || (EXE_MDUOp == OP_DIVU);
    op_signed = (EXE_MDUOp == OP_MULT) || (EXE_MDUOp == OP_DIV);
    start     = (state == S_IDLE) && EXE_MDUValid && (is_mul_op || is_div_op)
                && !EXE_Flush && !rst;

    // Magnitudes for the divider; 0x80000000 maps onto itself, which is the correct unsigned 2^31.
    mag_a = (op_signed && EXE_SrcA[31]) ? (32'd0 - EXE_SrcA) : EXE_SrcA;
    mag_b = (op_signed && EXE_SrcB[31]) ? (32'd0 - EXE_SrcB) : EXE_SrcB;

    // One 64x64 multiply covers both flavours: the low 64 bits of the extended product are exact.
    product = {{32{is_signed & op_a[31]}}, op_a} * {{32{is_signed & op_b[31]}}, op_b};

    // Restoring step: remainder < divisor, so bit 32 of the difference is a clean borrow flag.
    trial      = {rem, op_a[31]};
    trial_diff = trial - {1'b0, op_b};

    quot_fix = neg_q ? (32'd0 - op_a) : op_a;
    rem_fix  = neg_r ? (32'd0 - rem) : rem;
  end

  // Stall request and completion pulse; a flush in the DONE cycle suppresses the pulse.
  always_comb begin
    EXE_MDUBusy = start || (state == S_MUL) || (state == S_DIV);
    MDU_Done    = (state == S_DONE) && !EXE_Flush && !rst;
  end

  // Sequencer, operand latches and HI/LO writes; flush overrides everything except reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 6'd0;
      op_a      <= 32'd0;
      op_b      <= 32'd0;
      rem       <= 32'd0;
      is_signed <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      HI        <= 32'd0;
      LO        <= 32'd0;
    end else if (EXE_Flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            is_signed <= op_signed;
            neg_q     <= op_signed & (EXE_SrcA[31] ^ EXE_SrcB[31]);
            neg_r     <= op_signed & EXE_SrcA[31];
            rem       <= 32'd0;
            if (is_mul_op) begin
              op_a  <= EXE_SrcA;
              op_b  <= EXE_SrcB;
              cnt   <= MUL_CNT_INIT;
              state <= S_MUL;
            end else begin
              op_a <= mag_a;
              op_b <= mag_b;
              // Divide-by-zero leaves HI/LO untouched but still completes through DONE.
              if (EXE_SrcB == 32'd0) begin
                state <= S_DONE;
              end else begin
                cnt   <= DIV_CNT_INIT;
                state <= S_DIV;
              end
            end
          end else if (EXE_MDUValid && (EXE_MDUOp == OP_MTHI)) begin
            HI <= EXE_SrcA;
          end else if (EXE_MDUValid && (EXE_MDUOp == OP_MTLO)) begin
            LO <= EXE_SrcA;
          end
        end
        S_MUL: begin
          if (cnt == 6'd0) begin
            {HI, LO} <= product;
            state    <= S_DONE;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        S_DIV: begin
          if (cnt == 6'd0) begin
            LO    <= quot_fix;
            HI    <= rem_fix;
            state <= S_DONE;
          end else begin
            rem  <= trial_diff[32] ? trial[31:0] : trial_diff[31:0];
            op_a <= {op_a[30:0], ~trial_diff[32]};
            cnt  <= cnt - 6'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exe_mdu.sv
// tb_exe_mdu: directed vectors for exe_mdu with a HI/LO scoreboard popped on every MDU_Done pulse.
// Latency: each op is followed until its DONE pulse or a 200-cycle bound; busy-cycle counts are checked per op.
// Backpressure: operands are held (then scrambled) while EXE_MDUBusy is high; EXE_MDUValid stays high through DONE.
module tb_exe_mdu;

  localparam int MUL_CYCLES = 2;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic        clk = 1'b0;
  logic        rst;
  logic        EXE_Flush;
  logic        EXE_MDUValid;
  logic [2:0]  EXE_MDUOp;
  logic [31:0] EXE_SrcA;
  logic [31:0] EXE_SrcB;
  logic        EXE_MDUBusy;
  logic        MDU_Done;
  logic [31:0] HI;
  logic [31:0] LO;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] sb_q[$];
  string       sb_name[$];
  logic [63:0] mon_exp;
  string       mon_name;

  exe_mdu #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk          (clk),
    .rst          (rst),
    .EXE_Flush    (EXE_Flush),
    .EXE_MDUValid (EXE_MDUValid),
    .EXE_MDUOp    (EXE_MDUOp),
    .EXE_SrcA     (EXE_SrcA),
    .EXE_SrcB     (EXE_SrcB),
    .EXE_MDUBusy  (EXE_MDUBusy),
    .MDU_Done     (MDU_Done),
    .HI           (HI),
    .LO           (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every completion pulse must match the oldest outstanding expected HI/LO.
  always @(negedge clk) begin
    if (rst === 1'b0 && MDU_Done === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: MDU_Done=1 with nothing outstanding (HI=0x%08h LO=0x%08h)", HI, LO);
      end else begin
        mon_exp  = sb_q.pop_front();
        mon_name = sb_name.pop_front();
        check({mon_name, "_hi"}, HI, mon_exp[63:32]);
        check({mon_name, "_lo"}, LO, mon_exp[31:0]);
      end
    end
  end

  // Issue a MULT/DIV op, count busy cycles up to DONE, then drop valid one cycle after DONE.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_busy,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int busy_n;
    int t;
    sb_q.push_back({ehi, elo});
    sb_name.push_back(name);
    @(posedge clk); #1;
    EXE_MDUValid = 1'b1;
    EXE_MDUOp    = op;
    EXE_SrcA     = a;
    EXE_SrcB     = b;
    busy_n = 0;
    t      = 0;
    @(negedge clk);
    while (MDU_Done !== 1'b1 && t < 200) begin
      if (EXE_MDUBusy === 1'b1) busy_n++;
      if (t == 1) begin
        EXE_SrcA = ~a;
        EXE_SrcB = b ^ 32'h0000_0005;
      end
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: no MDU_Done within 200 cycles, required a pulse", name);
    end else begin
      check({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
      check({name, "_busy_in_done"}, 32'(EXE_MDUBusy), 32'd0);
    end
    @(posedge clk); #1;
    EXE_MDUValid = 1'b0;
    EXE_MDUOp    = OP_NONE;
    @(negedge clk);
    check({name, "_single_done"}, 32'(MDU_Done), 32'd0);
    check({name, "_no_restart"}, 32'(EXE_MDUBusy), 32'd0);
  endtask

  // MTHI/MTLO for one cycle, optionally with flush; busy must stay low, HI/LO checked next cycle.
  task automatic run_mt(input string name, input logic [2:0] op, input logic [31:0] d,
                        input logic flush, input logic [31:0] ehi, input logic [31:0] elo);
    @(posedge clk); #1;
    EXE_MDUValid = 1'b1;
    EXE_MDUOp    = op;
    EXE_SrcA     = d;
    EXE_SrcB     = ~d;
    EXE_Flush    = flush;
    @(negedge clk);
    check({name, "_busy"}, 32'(EXE_MDUBusy), 32'd0);
    @(posedge clk); #1;
    EXE_MDUValid = 1'b0;
    EXE_MDUOp    = OP_NONE;
    EXE_Flush    = 1'b0;
    @(negedge clk);
    check({name, "_hi"}, HI, ehi);
    check({name, "_lo"}, LO, elo);
    check({name, "_busy_after"}, 32'(EXE_MDUBusy), 32'd0);
  endtask

  // DIV flushed on its 10th busy cycle: must return idle with HI/LO untouched and never pulse done.
  task automatic run_flush_div(input logic [31:0] ehi, input logic [31:0] elo);
    int done_n;
    @(posedge clk); #1;
    EXE_MDUValid = 1'b1;
    EXE_MDUOp    = OP_DIV;
    EXE_SrcA     = 32'd100;
    EXE_SrcB     = 32'd3;
    repeat (9) begin
      @(posedge clk); #1;
    end
    EXE_Flush = 1'b1;
    @(negedge clk);
    check("flush_busy_at_cycle10", 32'(EXE_MDUBusy), 32'd1);
    @(posedge clk); #1;
    EXE_Flush    = 1'b0;
    EXE_MDUValid = 1'b0;
    EXE_MDUOp    = OP_NONE;
    @(negedge clk);
    check("flush_busy_after", 32'(EXE_MDUBusy), 32'd0);
    check("flush_hi_hold", HI, ehi);
    check("flush_lo_hold", LO, elo);
    done_n = 0;
    repeat (40) begin
      @(negedge clk);
      if (MDU_Done === 1'b1) done_n++;
    end
    check("flush_no_done", 32'(done_n), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    EXE_Flush    = 1'b0;
    EXE_MDUValid = 1'b0;
    EXE_MDUOp    = OP_NONE;
    EXE_SrcA     = 32'd0;
    EXE_SrcB     = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    check("reset_busy", 32'(EXE_MDUBusy), 32'd0);
    check("reset_done", 32'(MDU_Done), 32'd0);

    run_op("mult_neg1x2",  OP_MULT,  32'hFFFF_FFFF, 32'd2, 1 + MUL_CYCLES, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu_max_x2", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1 + MUL_CYCLES, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mult_min_sq",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 1 + MUL_CYCLES, 32'h4000_0000, 32'h0000_0000);
    run_op("mult_m3x5",    OP_MULT,  32'hFFFF_FFFD, 32'd5, 1 + MUL_CYCLES, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("div_m7_2",     OP_DIV,   32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_big_2",   OP_DIVU,  32'hFFFF_FFF9, 32'd2, 34, 32'h0000_0001, 32'h7FFF_FFFC);
    run_op("div_7_m2",     OP_DIV,   32'd7, 32'hFFFF_FFFE, 34, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu_100_7",   OP_DIVU,  32'd100, 32'd7, 34, 32'h0000_0002, 32'h0000_000E);
    run_op("div_min_m1",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h8000_0000);
    run_op("div_by_zero",  OP_DIV,   32'd5, 32'd0, 1, 32'h0000_0000, 32'h8000_0000);

    run_mt("mtlo",         OP_MTLO, 32'h1234_5678, 1'b0, 32'h0000_0000, 32'h1234_5678);
    run_mt("mthi",         OP_MTHI, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 32'h1234_5678);
    run_mt("mthi_flushed", OP_MTHI, 32'h1111_1111, 1'b1, 32'hCAFE_F00D, 32'h1234_5678);

    run_flush_div(32'hCAFE_F00D, 32'h1234_5678);
    run_op("multu_after_flush", OP_MULTU, 32'd3, 32'd4, 1 + MUL_CYCLES, 32'h0000_0000, 32'h0000_000C);

    // Reset in the middle of a multiply clears HI/LO and the sequencer.
    run_op("multu_pre_rst", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 1 + MUL_CYCLES, 32'h0000_0001, 32'h0000_0000);
    @(posedge clk); #1;
    EXE_MDUValid = 1'b1;
    EXE_MDUOp    = OP_MULTU;
    EXE_SrcA     = 32'hFFFF_FFFF;
    EXE_SrcB     = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    rst          = 1'b1;
    EXE_MDUValid = 1'b0;
    EXE_MDUOp    = OP_NONE;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_hi", HI, 32'd0);
    check("midrst_lo", LO, 32'd0);
    check("midrst_busy", 32'(EXE_MDUBusy), 32'd0);
    repeat (5) @(negedge clk);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded 100000 time units, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/exe_mdu.md
Name: exe_mdu

Overview:
- EXE-stage multiply/divide unit with the architectural HI/LO registers.
- Consumes the forwarded operands selected by the EXE forwarding muxes: rs-side and rt-side after forwarding from MEM/MEM2/WB.
- Runs multi-cycle MULT/MULTU/DIV/DIVU and single-cycle MTHI/MTLO.
- Raises a busy/stall request so the hazard logic holds IF..EXE until the result is in HI/LO.

Parameters:
- MUL_CYCLES, 2, cycles spent in MUL state (legal 1..8). Models a multi-cycle multiplier; product is computed from latched operands and written at end of MUL state.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- EXE_Flush  input  1  abort current/pending MDU op (exception/branch flush)
- EXE_MDUValid  input  1  EXE holds a valid MDU instruction
- EXE_MDUOp  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none
- EXE_SrcA  input  32  forwarded rs value (dividend / multiplicand / MTHI-MTLO data)
- EXE_SrcB  input  32  forwarded rt value (divisor / multiplier)
- EXE_MDUBusy  output  1  stall request to hazard unit
- MDU_Done  output  1  one-cycle pulse: HI/LO just updated by MULT/DIV result
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- States: IDLE, MUL, DIV, DONE. Iteration counter is 6 bits.
- Reset: state=IDLE, HI=0, LO=0, EXE_MDUBusy=0, MDU_Done=0, counter=0, operand latches=0.
- start = (state==IDLE) && EXE_MDUValid && op in {MULT, MULTU, DIV, DIVU} && !EXE_Flush.
- EXE_MDUBusy (combinational) = start || state==MUL || state==DIV.
- IDLE + start:
  - Latch SrcA/SrcB, op signedness and result signs.
  - MULT/MULTU: go to MUL with counter=MUL_CYCLES-1.
  - DIV/DIVU with SrcB!=0: go to DIV with counter=32.
  - DIV/DIVU with SrcB==0: go to DONE directly; HI/LO unchanged; MDU_Done still pulses.
- MUL:
  - Decrement counter each cycle.
  - When counter==0: write {HI,LO} = 64-bit product (signed for MULT, unsigned for MULTU), go to DONE.
  - Total busy cycles = 1 + MUL_CYCLES.
- DIV: restoring radix-2 on magnitudes.
  - Counter 32..1: one quotient bit per cycle, MSB first.
  - Counter 0: sign fixup cycle, then write LO=quotient, HI=remainder, go to DONE.
  - Total busy cycles = 1 + 33 = 34.
  - Quotient sign = signA^signB (signed only); remainder sign = signA.
  - 0x80000000 / 0xFFFFFFFF signed gives LO=0x80000000, HI=0 (magnitude arithmetic wraps).
- DONE:
  - Exactly one cycle; MDU_Done=1, EXE_MDUBusy=0; the pipeline advances.
  - EXE_MDUValid is ignored here, since it is still the same instruction.
  - Next state is IDLE.
- MTHI/MTLO:
  - In IDLE with EXE_MDUValid && !EXE_Flush, write HI (or LO) = SrcA at the edge.
  - No busy, no MDU_Done; new value is visible the next cycle.
- EXE_Flush:
  - In any state, forces state to IDLE at the edge and discards the op; HI/LO unchanged; MDU_Done=0.
  - Flush has priority over start, MTHI/MTLO and completion in the same cycle.
- Operand changes on SrcA/SrcB after start are ignored, because latched values are used.
- rst mid-operation: same as reset; HI/LO cleared.

Test Plan:
- Reset, then MULT SrcA=0xFFFFFFFF SrcB=2 (MUL_CYCLES=2) -> busy for 3 cycles, DONE pulse, HI=0xFFFFFFFF LO=0xFFFFFFFE.
- MULTU same operands -> HI=0x00000001 LO=0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 2 -> busy 34 cycles, LO=0xFFFFFFFD HI=0xFFFFFFFF.
- DIVU 0xFFFFFFF9 / 2 -> LO=0x7FFFFFFC HI=0x00000001.
- Corner divides:
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000 HI=0.
  - DIV x/0 -> busy 1 cycle, MDU_Done pulses, HI/LO unchanged.
- Control interactions:
  - MTLO 0x12345678 -> LO updated next cycle, busy never high.
  - DIV with EXE_Flush on busy cycle 10 -> IDLE next cycle, HI/LO hold prior values, no MDU_Done.
  - EXE_MDUValid held high through DONE -> no second start.
